// File: rtl/avmm_avst_cmd_bridge.sv
// Avalon-MM slave to Avalon-ST command bridge.
// Accepted reads/writes become packed commands {is_write, address, writedata}
// held in a single output register. Read responses return on avs_readdata one
// cycle after arrival. A credit counter bounds the number of outstanding reads,
// so the response path never needs backpressure.
module avmm_avst_cmd_bridge #(
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int MAX_PENDING = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            avs_address,
    input  logic                             avs_read,
    input  logic                             avs_write,
    input  logic [DATA_WIDTH-1:0]            avs_writedata,
    output logic                             avs_waitrequest,
    output logic [DATA_WIDTH-1:0]            avs_readdata,
    output logic                             avs_readdatavalid,
    output logic [DATA_WIDTH+ADDR_WIDTH:0]   avst_avcmd_data,
    output logic                             avst_avcmd_valid,
    input  logic                             avst_avcmd_ready,
    input  logic [DATA_WIDTH-1:0]            avst_rd_rsp_data,
    input  logic                             avst_rd_rsp_valid,
    output logic                             avst_rd_rsp_ready,
    output logic [$clog2(MAX_PENDING):0]     pending_count,
    output logic                             idle,
    output logic [1:0]                       err_sticky
);

    localparam int CNT_W = $clog2(MAX_PENDING) + 1;
    localparam int CMD_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic                  cmd_vld_q,  cmd_vld_d;
    logic [CMD_W-1:0]      cmd_data_q, cmd_data_d;
    logic [CNT_W-1:0]      pend_q,     pend_d;
    logic                  rsp_vld_q,  rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            err_q,      err_d;

    logic full;
    logic accept;
    logic rd_accept;
    logic both_accept;
    logic rsp_fire;
    logic rsp_ok;
    logic rsp_stray;

    // Handshake qualifiers: stall, accept and response classification.
    always_comb begin
        full              = (pend_q == PEND_MAX);
        avst_rd_rsp_ready = ~reset;
        // Reset forces a stall so nothing is accepted while state is being cleared.
        avs_waitrequest   = reset | (cmd_vld_q & ~avst_avcmd_ready) | full;
        accept            = (avs_read | avs_write) & ~avs_waitrequest;
        // Simultaneous read+write is taken as a write only; it consumes no credit.
        rd_accept         = accept & avs_read & ~avs_write;
        both_accept       = accept & avs_read & avs_write;
        rsp_fire          = avst_rd_rsp_valid & avst_rd_rsp_ready;
        rsp_ok            = rsp_fire & (pend_q != '0);
        rsp_stray         = rsp_fire & (pend_q == '0);
    end

    // Next-state for command register, credit counter, response stage and errors.
    always_comb begin
        cmd_vld_d  = cmd_vld_q;
        cmd_data_d = cmd_data_q;
        pend_d     = pend_q;
        rsp_vld_d  = rsp_ok;
        rsp_data_d = rsp_data_q;
        err_d      = err_q | {rsp_stray, both_accept};

        // A new accept overrides a drain in the same cycle, giving full throughput.
        if (accept) begin
            cmd_vld_d  = 1'b1;
            cmd_data_d = {avs_write, avs_address,
                          avs_write ? avs_writedata : {DATA_WIDTH{1'b0}}};
        end else if (avst_avcmd_ready) begin
            cmd_vld_d  = 1'b0;
        end

        case ({rd_accept, rsp_ok})
            2'b10:   pend_d = pend_q + PEND_ONE;
            2'b01:   pend_d = pend_q - PEND_ONE;
            default: pend_d = pend_q;
        endcase

        if (rsp_ok) begin
            rsp_data_d = avst_rd_rsp_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_vld_q  <= 1'b0;
            cmd_data_q <= '0;
            pend_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= '0;
        end else begin
            cmd_vld_q  <= cmd_vld_d;
            cmd_data_q <= cmd_data_d;
            pend_q     <= pend_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    // Output mapping from registered state.
    always_comb begin
        avst_avcmd_valid  = cmd_vld_q;
        avst_avcmd_data   = cmd_data_q;
        avs_readdatavalid = rsp_vld_q;
        avs_readdata      = rsp_data_q;
        pending_count     = pend_q;
        err_sticky        = err_q;
        idle              = ~cmd_vld_q & (pend_q == '0);
    end

endmodule

// File: tb/tb_avmm_avst_cmd_bridge.sv
// Scoreboard bench for avmm_avst_cmd_bridge: stimulus pushes expected commands
// and read responses into queues; a negedge monitor pops and compares them.
module tb_avmm_avst_cmd_bridge;

    localparam int AW = 48;
    localparam int DW = 512;
    localparam int MP = 64;
    localparam int CW = DW + AW + 1;
    localparam int PW = $clog2(MP) + 1;

    logic          clk;
    logic          reset;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [DW-1:0] avs_writedata;
    logic          avs_waitrequest;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;
    logic [CW-1:0] avst_avcmd_data;
    logic          avst_avcmd_valid;
    logic          avst_avcmd_ready;
    logic [DW-1:0] avst_rd_rsp_data;
    logic          avst_rd_rsp_valid;
    logic          avst_rd_rsp_ready;
    logic [PW-1:0] pending_count;
    logic          idle;
    logic [1:0]    err_sticky;

    int errors = 0;
    int checks = 0;
    int n_xfer = 0;
    int x0;

    logic [CW-1:0] cmd_q[$];
    logic [DW-1:0] rsp_q[$];
    logic [CW-1:0] w1;

    avmm_avst_cmd_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_PENDING(MP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_waitrequest  (avs_waitrequest),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avst_avcmd_data  (avst_avcmd_data),
        .avst_avcmd_valid (avst_avcmd_valid),
        .avst_avcmd_ready (avst_avcmd_ready),
        .avst_rd_rsp_data (avst_rd_rsp_data),
        .avst_rd_rsp_valid(avst_rd_rsp_valid),
        .avst_rd_rsp_ready(avst_rd_rsp_ready),
        .pending_count    (pending_count),
        .idle             (idle),
        .err_sticky       (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chks(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] line(input logic [31:0] v);
        return {16{v}};
    endfunction

    function automatic logic [CW-1:0] rd_cmd(input logic [AW-1:0] a);
        return {1'b0, a, {DW{1'b0}}};
    endfunction

    function automatic logic [CW-1:0] wr_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every command transfer and every readdatavalid pops the scoreboard.
    always @(negedge clk) begin
        if (avst_avcmd_valid === 1'b1 && avst_avcmd_ready === 1'b1) begin
            n_xfer++;
            if (cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got %0h expected no command", avst_avcmd_data);
            end else begin
                chk("cmd", avst_avcmd_data, cmd_q.pop_front());
            end
        end
        if (avs_readdatavalid === 1'b1) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %0h expected no response", avs_readdata);
            end else begin
                chk("rsp", CW'(avs_readdata), CW'(rsp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        avs_read          = 1'b0;
        avs_write         = 1'b0;
        avs_address       = '0;
        avs_writedata     = '0;
        avst_avcmd_ready  = 1'b1;
        avst_rd_rsp_valid = 1'b0;
        avst_rd_rsp_data  = '0;
        tick;
        tick;

        // Reset values
        @(negedge clk);
        chks("rst_wait",  32'(avs_waitrequest),   32'd1);
        chks("rst_rready", 32'(avst_rd_rsp_ready), 32'd0);
        chks("rst_valid", 32'(avst_avcmd_valid),  32'd0);
        chks("rst_rdv",   32'(avs_readdatavalid), 32'd0);
        chk ("rst_rdata", CW'(avs_readdata),      '0);
        chks("rst_pend",  32'(pending_count),     32'd0);
        chks("rst_err",   32'(err_sticky),        32'd0);

        // Single write, issued in the first cycle out of reset
        tick;
        reset         = 1'b0;
        avs_write     = 1'b1;
        avs_address   = 48'h1000;
        avs_writedata = line(32'hA5A5_A5A5);
        cmd_q.push_back(wr_cmd(48'h1000, line(32'hA5A5_A5A5)));
        @(negedge clk);
        chks("first_wait", 32'(avs_waitrequest), 32'd0);
        chks("rready",     32'(avst_rd_rsp_ready), 32'd1);
        tick;
        avs_write = 1'b0;
        @(negedge clk);
        chks("wr_valid", 32'(avst_avcmd_valid), 32'd1);
        chks("wr_idle0", 32'(idle), 32'd0);
        tick;
        @(negedge clk);
        chks("wr_valid0", 32'(avst_avcmd_valid), 32'd0);
        chks("wr_idle1",  32'(idle), 32'd1);

        // 64 back-to-back reads fill the credits
        for (int i = 0; i < 64; i++) begin
            tick;
            avs_read    = 1'b1;
            avs_address = AW'(32'h10000 + i * 64);
            cmd_q.push_back(rd_cmd(AW'(32'h10000 + i * 64)));
        end
        tick;
        avs_address = 48'h20000;
        @(negedge clk);
        chks("full_pend", 32'(pending_count), 32'd64);
        chks("full_wait", 32'(avs_waitrequest), 32'd1);
        tick;
        avst_rd_rsp_valid = 1'b1;
        avst_rd_rsp_data  = line(32'hD000_0000);
        rsp_q.push_back(line(32'hD000_0000));
        @(negedge clk);
        chks("full_wait2", 32'(avs_waitrequest), 32'd1);
        tick;
        avst_rd_rsp_valid = 1'b0;
        cmd_q.push_back(rd_cmd(48'h20000));
        @(negedge clk);
        chks("rsp1_rdv",  32'(avs_readdatavalid), 32'd1);
        chks("rsp1_pend", 32'(pending_count), 32'd63);
        chks("rsp1_wait", 32'(avs_waitrequest), 32'd0);
        tick;
        avs_read = 1'b0;
        @(negedge clk);
        chks("rd65_pend",  32'(pending_count), 32'd64);
        chks("rd65_valid", 32'(avst_avcmd_valid), 32'd1);

        // Drain down to 5 outstanding
        for (int i = 1; i <= 59; i++) begin
            tick;
            avst_rd_rsp_valid = 1'b1;
            avst_rd_rsp_data  = line(32'hD000_0000 + 32'(i));
            rsp_q.push_back(line(32'hD000_0000 + 32'(i)));
        end
        tick;
        avst_rd_rsp_valid = 1'b0;
        @(negedge clk);
        chks("drain_pend5", 32'(pending_count), 32'd5);

        // Read accept and response in the same cycle
        tick;
        avs_read          = 1'b1;
        avs_address       = 48'h30000;
        cmd_q.push_back(rd_cmd(48'h30000));
        avst_rd_rsp_valid = 1'b1;
        avst_rd_rsp_data  = line(32'hE000_0005);
        rsp_q.push_back(line(32'hE000_0005));
        tick;
        avs_read          = 1'b0;
        avst_rd_rsp_valid = 1'b0;
        @(negedge clk);
        chks("same_pend", 32'(pending_count), 32'd5);
        chks("same_rdv",  32'(avs_readdatavalid), 32'd1);

        for (int i = 0; i < 5; i++) begin
            tick;
            avst_rd_rsp_valid = 1'b1;
            avst_rd_rsp_data  = line(32'hF000_0000 + 32'(i));
            rsp_q.push_back(line(32'hF000_0000 + 32'(i)));
        end
        tick;
        avst_rd_rsp_valid = 1'b0;
        @(negedge clk);
        chks("drain_pend0", 32'(pending_count), 32'd0);
        chks("drain_idle",  32'(idle), 32'd1);

        // Backpressure on the command output for 10 cycles
        tick;
        w1               = wr_cmd(48'h2000, line(32'h5A5A_0041));
        avs_write        = 1'b1;
        avs_address      = 48'h2000;
        avs_writedata    = line(32'h5A5A_0041);
        avst_avcmd_ready = 1'b0;
        cmd_q.push_back(w1);
        x0 = n_xfer;
        tick;
        avs_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chks("bp_wait",  32'(avs_waitrequest), 32'd1);
            chks("bp_valid", 32'(avst_avcmd_valid), 32'd1);
            chk ("bp_data",  avst_avcmd_data, w1);
            tick;
        end
        avst_avcmd_ready = 1'b1;
        @(negedge clk);
        chks("bp_release_wait", 32'(avs_waitrequest), 32'd0);
        tick;
        @(negedge clk);
        chks("bp_valid0", 32'(avst_avcmd_valid), 32'd0);
        chks("bp_xfers",  32'(n_xfer - x0), 32'd1);

        // Stray response with no credits outstanding
        tick;
        avst_rd_rsp_valid = 1'b1;
        avst_rd_rsp_data  = line(32'hBAD0_0001);
        tick;
        avst_rd_rsp_valid = 1'b0;
        @(negedge clk);
        chks("stray_rdv", 32'(avs_readdatavalid), 32'd0);
        chks("stray_err", 32'(err_sticky), 32'd2);

        // Read and write together: write command, error bit 0
        tick;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        avs_address   = 48'h4000;
        avs_writedata = line(32'h0000_C0DE);
        cmd_q.push_back(wr_cmd(48'h4000, line(32'h0000_C0DE)));
        tick;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        @(negedge clk);
        chks("rw_valid", 32'(avst_avcmd_valid), 32'd1);
        chks("rw_err",   32'(err_sticky), 32'd3);
        chks("rw_pend",  32'(pending_count), 32'd0);

        // Reset mid-operation: 3 reads outstanding, last one still buffered
        tick;
        avs_read    = 1'b1;
        avs_address = 48'h5000;
        cmd_q.push_back(rd_cmd(48'h5000));
        tick;
        avs_address = 48'h5040;
        cmd_q.push_back(rd_cmd(48'h5040));
        tick;
        avs_address = 48'h5080;
        tick;
        avs_read         = 1'b0;
        avst_avcmd_ready = 1'b0;
        reset            = 1'b1;
        @(negedge clk);
        chks("pre_rst_pend",  32'(pending_count), 32'd3);
        chks("pre_rst_valid", 32'(avst_avcmd_valid), 32'd1);
        chks("in_rst_wait",   32'(avs_waitrequest), 32'd1);
        tick;
        reset            = 1'b0;
        avst_avcmd_ready = 1'b1;
        @(negedge clk);
        chks("post_rst_valid", 32'(avst_avcmd_valid), 32'd0);
        chks("post_rst_pend",  32'(pending_count), 32'd0);
        chks("post_rst_err",   32'(err_sticky), 32'd0);
        chks("post_rst_idle",  32'(idle), 32'd1);
        tick;
        avst_rd_rsp_valid = 1'b1;
        avst_rd_rsp_data  = line(32'hBAD0_0002);
        tick;
        avst_rd_rsp_valid = 1'b0;
        @(negedge clk);
        chks("post_rst_stray_rdv", 32'(avs_readdatavalid), 32'd0);
        chks("post_rst_stray_err", 32'(err_sticky), 32'd2);

        tick;
        tick;
        chks("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        chks("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avmm_avst_cmd_bridge.md
AVMM_AVST_CMD_BRIDGE -- requirements
Module: avmm_avst_cmd_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 48, byte address width of the host command.
REQ-002 Parameter DATA_WIDTH, default 512, data width of one line.
REQ-003 Parameter MAX_PENDING, default 64, maximum outstanding reads; power of two, at least 2.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port avs_address, input, ADDR_WIDTH, slave byte address, line aligned.
REQ-007 Port avs_read, input, 1, read request.
REQ-008 Port avs_write, input, 1, write request.
REQ-009 Port avs_writedata, input, DATA_WIDTH, write line.
REQ-010 Port avs_waitrequest, output, 1, slave stall.
REQ-011 Port avs_readdata, output, DATA_WIDTH, read line.
REQ-012 Port avs_readdatavalid, output, 1, read line valid.
REQ-013 Port avst_avcmd_data, output, DATA_WIDTH+ADDR_WIDTH+1, packed command.
REQ-014 Port avst_avcmd_valid, output, 1, command valid.
REQ-015 Port avst_avcmd_ready, input, 1, command accepted by host stage.
REQ-016 Port avst_rd_rsp_data, input, DATA_WIDTH, read response line.
REQ-017 Port avst_rd_rsp_valid, input, 1, response valid.
REQ-018 Port avst_rd_rsp_ready, output, 1, response ready.
REQ-019 Port pending_count, output, clog2(MAX_PENDING)+1, outstanding reads.
REQ-020 Port idle, output, 1, no buffered command and no outstanding read.
REQ-021 Port err_sticky, output, 2, bit0 = read and write asserted together, bit1 = unexpected response.

Function
REQ-022 The command packing SHALL be {is_write, address, writedata}: MSB = 1 for write; address in [DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH]; writedata in [DATA_WIDTH-1:0]; writedata bits SHALL be 0 for reads.
REQ-023 The block SHALL hold one command output register (cmd_vld); avst_avcmd_valid SHALL equal cmd_vld.
REQ-024 avs_waitrequest SHALL be combinational: (cmd_vld and not avst_avcmd_ready) or (pending_count == MAX_PENDING).
REQ-025 A request SHALL be accepted when (avs_read or avs_write) and not avs_waitrequest; on acceptance the command SHALL be loaded into the register and appear on avst_avcmd_valid the next cycle (1-cycle latency).
REQ-026 cmd_vld SHALL clear when avst_avcmd_ready is high with no new accept; accept and drain in the same cycle SHALL keep cmd_vld = 1 and carry the new command (full throughput).
REQ-027 Read and write asserted together SHALL be accepted as a write only, SHALL NOT change pending_count, and SHALL set err_sticky[0].
REQ-028 pending_count SHALL increment on read accept, decrement on response receipt, and stay unchanged when both occur in the same cycle.
REQ-029 pending_count SHALL never exceed MAX_PENDING and SHALL never wrap below 0.
REQ-030 avst_rd_rsp_ready SHALL be constantly 1 outside reset; Avalon readdata carries no backpressure, and credits bound outstanding reads.
REQ-031 A response SHALL appear on avs_readdata/avs_readdatavalid exactly one cycle after avst_rd_rsp_valid, in arrival order.
REQ-032 A response arriving with pending_count == 0 SHALL be dropped (no readdatavalid) and SHALL set err_sticky[1].
REQ-033 idle SHALL equal (not cmd_vld) and (pending_count == 0), registered-state based.
REQ-034 err_sticky bits SHALL hold until reset.

Reset
REQ-035 While reset is high: avst_avcmd_valid = 0, avs_readdatavalid = 0, avs_readdata = 0, pending_count = 0, err_sticky = 0, avst_rd_rsp_ready = 0, avs_waitrequest = 1.
REQ-036 Reset mid-operation SHALL discard the buffered command and clear credits; any later responses belonging to pre-reset reads SHALL be treated per REQ-032.
REQ-037 The first accept SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-038 Single write at 0x1000, data 0xA5 repeated, ready = 1 -> next cycle valid = 1 with MSB 1, address 0x1000, data 0xA5 repeated; idle returns to 1 one cycle later.
REQ-039 64 back-to-back reads, no responses, ready = 1 -> pending_count = 64, waitrequest = 1 on the 65th read; one response -> readdatavalid 1 cycle later, count 63, 65th read accepted.
REQ-040 Read accept and response in the same cycle at count 5 -> count stays 5; readdatavalid asserts next cycle.
REQ-041 avst_avcmd_ready = 0 for 10 cycles with a write pending -> waitrequest = 1 throughout, command stable, no loss; ready = 1 -> exactly one command transfer.
REQ-042 Response with pending_count = 0 -> no readdatavalid, err_sticky = 2'b10; read and write together -> write command emitted, err_sticky[0] set.
REQ-043 Reset asserted with 3 reads outstanding and cmd_vld = 1 -> next cycle valid = 0, count = 0; a post-reset stray response sets err_sticky[1].
